// File: rtl/ac_motor_pkg.sv
// Shared definitions for the AC motor PWM blocks.
package ac_motor_pkg;

    localparam int unsigned DEF_CNT_BITS = 16;
    // Matches the comparator's default dead time of one cycle.
    localparam int unsigned DEF_MIN_DEAD = 1;
    localparam int unsigned DEF_GAP_BITS = 4;

    typedef logic [2:0] gap_state_t;

    localparam gap_state_t S_NONE = 3'd0;
    localparam gap_state_t S_HI1  = 3'd1;
    localparam gap_state_t S_HI2  = 3'd2;
    localparam gap_state_t S_GAP1 = 3'd3;
    localparam gap_state_t S_GAP2 = 3'd4;

endpackage

// File: rtl/ac_motor_sat_counter.sv
// Saturating up-counter with a synchronous load and a sticky overflow flag.
module ac_motor_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    // Load has priority. An increment at all-ones holds the count and flags overflow.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            ovf <= 1'b0;
        end else if (inc) begin
            if (&cnt) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/ac_motor_pwm_decoder.sv
// Read-back monitor for H-bridge gate commands: per-period duty/dead decode
// plus sticky shoot-through and dead-time fault detection.
module ac_motor_pwm_decoder
    import ac_motor_pkg::*;
#(
    parameter int unsigned CNT_BITS = DEF_CNT_BITS,
    parameter int unsigned MIN_DEAD = DEF_MIN_DEAD,
    parameter int unsigned GAP_BITS = DEF_GAP_BITS
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       IN1,
    input  logic                       IN2,
    input  logic                       SYNC,
    input  logic                       CLEAR,
    output logic signed [CNT_BITS:0]   DUTY,
    output logic        [CNT_BITS-1:0] DEAD,
    output logic                       VALID,
    output logic                       OVF,
    output logic                       SHOOT_FAULT,
    output logic                       DEAD_FAULT
);

    localparam logic [GAP_BITS-1:0] GAP_MAX = '1;

    logic i1, i2, s;
    logic inc1, inc2, incz;
    logic [CNT_BITS-1:0] h1, h2, dz;
    logic ovf1, ovf2, ovfz;

    gap_state_t state, state_nx;
    logic [GAP_BITS-1:0] gap, gap_nx;
    logic shoot_evt_c, dead_evt_c;

    // Register the bridge commands and the period strobe once.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            i1 <= 1'b0;
            i2 <= 1'b0;
            s  <= 1'b0;
        end else begin
            i1 <= IN1;
            i2 <= IN2;
            s  <= SYNC;
        end
    end

    assign inc1 = i1 & ~i2;
    assign inc2 = i2 & ~i1;
    assign incz = ~i1 & ~i2;

    // On a period boundary each counter restarts holding the current sample.
    ac_motor_sat_counter #(.W(CNT_BITS)) u_cnt_h1 (
        .CLK(CLK), .RESET(RESET), .load(s), .load_val(CNT_BITS'(inc1)),
        .inc(inc1), .cnt(h1), .ovf(ovf1)
    );
    ac_motor_sat_counter #(.W(CNT_BITS)) u_cnt_h2 (
        .CLK(CLK), .RESET(RESET), .load(s), .load_val(CNT_BITS'(inc2)),
        .inc(inc2), .cnt(h2), .ovf(ovf2)
    );
    ac_motor_sat_counter #(.W(CNT_BITS)) u_cnt_dz (
        .CLK(CLK), .RESET(RESET), .load(s), .load_val(CNT_BITS'(incz)),
        .inc(incz), .cnt(dz), .ovf(ovfz)
    );

    // Publish the completed period; VALID marks the cycle the results change.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            DUTY  <= '0;
            DEAD  <= '0;
            OVF   <= 1'b0;
            VALID <= 1'b0;
        end else begin
            VALID <= s;
            if (s) begin
                DUTY <= $signed({1'b0, h1}) - $signed({1'b0, h2});
                DEAD <= dz;
                OVF  <= ovf1 | ovf2 | ovfz;
            end
        end
    end

    // Gap FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_NONE;
            gap   <= '0;
        end else begin
            state <= state_nx;
            gap   <= gap_nx;
        end
    end

    // Track which leg was last driven and how long both legs have been low.
    always_comb begin
        state_nx    = state;
        gap_nx      = gap;
        shoot_evt_c = 1'b0;
        dead_evt_c  = 1'b0;
        if (i1 && i2) begin
            shoot_evt_c = 1'b1;
            state_nx    = S_NONE;
        end else begin
            case (state)
                S_NONE: begin
                    if (i1)      state_nx = S_HI1;
                    else if (i2) state_nx = S_HI2;
                end
                S_HI1: begin
                    if (!i1 && !i2) begin
                        state_nx = S_GAP1;
                        gap_nx   = GAP_BITS'(1);
                    end else if (i2) begin
                        dead_evt_c = 1'b1;
                        state_nx   = S_HI2;
                    end
                end
                S_HI2: begin
                    if (!i1 && !i2) begin
                        state_nx = S_GAP2;
                        gap_nx   = GAP_BITS'(1);
                    end else if (i1) begin
                        dead_evt_c = 1'b1;
                        state_nx   = S_HI1;
                    end
                end
                S_GAP1: begin
                    if (i1) begin
                        state_nx = S_HI1;
                    end else if (i2) begin
                        dead_evt_c = (32'(gap) < MIN_DEAD);
                        state_nx   = S_HI2;
                    end else if (gap != GAP_MAX) begin
                        gap_nx = gap + GAP_BITS'(1);
                    end
                end
                S_GAP2: begin
                    if (i2) begin
                        state_nx = S_HI2;
                    end else if (i1) begin
                        dead_evt_c = (32'(gap) < MIN_DEAD);
                        state_nx   = S_HI1;
                    end else if (gap != GAP_MAX) begin
                        gap_nx = gap + GAP_BITS'(1);
                    end
                end
                default: state_nx = S_NONE;
            endcase
        end
    end

    // Sticky faults; a new event outranks a simultaneous CLEAR.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SHOOT_FAULT <= 1'b0;
            DEAD_FAULT  <= 1'b0;
        end else begin
            SHOOT_FAULT <= shoot_evt_c | (SHOOT_FAULT & ~CLEAR);
            DEAD_FAULT  <= dead_evt_c  | (DEAD_FAULT  & ~CLEAR);
        end
    end

endmodule

// File: tb/tb_ac_motor_pwm_decoder.sv
// Self-checking bench: two decoder instances (16-bit/MIN_DEAD 1 and
// 4-bit/MIN_DEAD 2) share one stimulus and are checked against a period model.
module tb_ac_motor_pwm_decoder;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic IN1 = 1'b0, IN2 = 1'b0, SYNC = 1'b0, CLEAR = 1'b0;

    logic signed [16:0] duty_a;
    logic        [15:0] dead_a;
    logic valid_a, ovf_a, shoot_a, deadf_a;
    logic signed [4:0]  duty_b;
    logic        [3:0]  dead_b;
    logic valid_b, ovf_b, shoot_b, deadf_b;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    ac_motor_pwm_decoder #(.CNT_BITS(16), .MIN_DEAD(1), .GAP_BITS(4)) dut_a (
        .CLK(CLK), .RESET(RESET), .IN1(IN1), .IN2(IN2), .SYNC(SYNC), .CLEAR(CLEAR),
        .DUTY(duty_a), .DEAD(dead_a), .VALID(valid_a), .OVF(ovf_a),
        .SHOOT_FAULT(shoot_a), .DEAD_FAULT(deadf_a)
    );

    ac_motor_pwm_decoder #(.CNT_BITS(4), .MIN_DEAD(2), .GAP_BITS(4)) dut_b (
        .CLK(CLK), .RESET(RESET), .IN1(IN1), .IN2(IN2), .SYNC(SYNC), .CLEAR(CLEAR),
        .DUTY(duty_b), .DEAD(dead_b), .VALID(valid_b), .OVF(ovf_b),
        .SHOOT_FAULT(shoot_b), .DEAD_FAULT(deadf_b)
    );

    // Reference model: per-period high/low counts and a last-leg/gap-length tracker.
    int h1[2], h2[2], dz[2], e_duty[2], e_dead[2], last_leg[2], gap_len[2];
    bit e_ovf[2], e_valid[2], e_shoot[2], e_deadf[2];
    bit m_i1, m_i2, m_s;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < 2; k++) begin
                h1[k] = 0; h2[k] = 0; dz[k] = 0; e_duty[k] = 0; e_dead[k] = 0;
                last_leg[k] = 0; gap_len[k] = 0;
                e_ovf[k] = 0; e_valid[k] = 0; e_shoot[k] = 0; e_deadf[k] = 0;
            end
            m_i1 = 0; m_i2 = 0; m_s = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int mx, mind, leg;
                bit a1, a2, lo, sh, dv;
                mx   = (k == 0) ? 65535 : 15;
                mind = (k == 0) ? 1 : 2;
                a1 = m_i1 && !m_i2;
                a2 = m_i2 && !m_i1;
                lo = !m_i1 && !m_i2;
                e_valid[k] = m_s;
                if (m_s) begin
                    e_duty[k] = imin(h1[k], mx) - imin(h2[k], mx);
                    e_dead[k] = imin(dz[k], mx);
                    e_ovf[k]  = (h1[k] > mx) || (h2[k] > mx) || (dz[k] > mx);
                    h1[k] = int'(a1); h2[k] = int'(a2); dz[k] = int'(lo);
                end else begin
                    h1[k] += int'(a1); h2[k] += int'(a2); dz[k] += int'(lo);
                end
                sh = m_i1 && m_i2;
                dv = 0;
                if (sh) begin
                    last_leg[k] = 0;
                    gap_len[k] = 0;
                end else if (a1 || a2) begin
                    leg = a1 ? 1 : 2;
                    if (last_leg[k] != 0 && last_leg[k] != leg && imin(gap_len[k], 15) < mind)
                        dv = 1;
                    last_leg[k] = leg;
                    gap_len[k] = 0;
                end else if (last_leg[k] != 0) begin
                    gap_len[k]++;
                end
                e_shoot[k] = sh || (e_shoot[k] && !CLEAR);
                e_deadf[k] = dv || (e_deadf[k] && !CLEAR);
            end
            m_i1 = IN1; m_i2 = IN2; m_s = SYNC;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_duty", duty_a, e_duty[0]);
        chk("a_dead", dead_a, e_dead[0]);
        chk("a_valid", valid_a, e_valid[0]);
        chk("a_ovf", ovf_a, e_ovf[0]);
        chk("a_shoot", shoot_a, e_shoot[0]);
        chk("a_deadf", deadf_a, e_deadf[0]);
        chk("b_duty", duty_b, e_duty[1]);
        chk("b_dead", dead_b, e_dead[1]);
        chk("b_valid", valid_b, e_valid[1]);
        chk("b_ovf", ovf_b, e_ovf[1]);
        chk("b_shoot", shoot_b, e_shoot[1]);
        chk("b_deadf", deadf_b, e_deadf[1]);
    endtask

    // Drive one cycle of inputs, let the edge pass, then check on the falling edge.
    task automatic tick(input bit a, input bit b, input bit sy, input bit cl);
        IN1 = a; IN2 = b; SYNC = sy; CLEAR = cl;
        @(posedge CLK);
        @(negedge CLK);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0);
    endtask

    task automatic clear_all();
        idle(4);
        tick(0, 0, 0, 1);
    endtask

    // One carrier period: first leg (with SYNC on its first cycle), gap, other leg, gap.
    task automatic period(input int first, input int n1, input int g1, input int n2, input int g2);
        for (int i = 0; i < n1; i++) tick(first == 1, first == 2, i == 0, 0);
        idle(g1);
        for (int i = 0; i < n2; i++) tick(first == 2, first == 1, 0, 0);
        idle(g2);
    endtask

    initial begin
        // Reset state
        RESET = 1'b1;
        idle(2);
        chk("rst_duty", duty_a, 0);
        chk("rst_dead", dead_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_shoot", shoot_a, 0);
        chk("rst_deadf", deadf_a, 0);
        RESET = 1'b0;

        // Steady PWM: 12 high / 1 dead / 6 high / 1 dead
        repeat (4) period(1, 12, 1, 6, 1);
        tick(1, 0, 1, 0);
        tick(1, 0, 0, 0);
        chk("steady_duty", duty_a, 6);
        chk("steady_dead", dead_a, 2);
        chk("steady_valid", valid_a, 1);
        chk("steady_ovf", ovf_a, 0);
        chk("steady_shoot", shoot_a, 0);
        chk("steady_deadf", deadf_a, 0);
        idle(2);

        // Mirror
        repeat (3) period(2, 12, 1, 6, 1);
        tick(0, 1, 1, 0);
        tick(0, 1, 0, 0);
        chk("mirror_duty", duty_a, -6);
        chk("mirror_dead", dead_a, 2);
        chk("mirror_valid", valid_a, 1);
        idle(2);

        // Overflow: IN1 held 20 cycles in one period
        tick(1, 0, 1, 0);
        repeat (19) tick(1, 0, 0, 0);
        tick(1, 0, 1, 0);
        tick(1, 0, 0, 0);
        chk("ovf_b_duty", duty_b, 15);
        chk("ovf_b_flag", ovf_b, 1);
        chk("ovf_a_duty", duty_a, 20);
        chk("ovf_a_flag", ovf_a, 0);
        idle(2);

        // Back-to-back SYNC: one-cycle period
        tick(1, 0, 1, 0);
        tick(1, 0, 1, 0);
        tick(1, 0, 1, 0);
        chk("b2b_duty", duty_a, 1);
        chk("b2b_dead", dead_a, 0);
        chk("b2b_valid", valid_a, 1);

        // Shoot-through, sticky until CLEAR
        clear_all();
        tick(1, 1, 0, 0);
        tick(0, 0, 0, 0);
        chk("shoot_set", shoot_a, 1);
        idle(3);
        chk("shoot_sticky", shoot_a, 1);
        tick(0, 0, 0, 1);
        chk("shoot_clear", shoot_a, 0);

        // CLEAR coincident with a new shoot-through
        tick(1, 1, 0, 0);
        tick(0, 0, 0, 1);
        chk("shoot_clr_race", shoot_a, 1);

        // One-cycle gap violates MIN_DEAD=2 only
        clear_all();
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        chk("gap1_b_deadf", deadf_b, 1);
        chk("gap1_a_deadf", deadf_a, 0);

        // Direct swap with no gap
        clear_all();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        chk("swap_a_deadf", deadf_a, 1);
        chk("swap_b_deadf", deadf_b, 1);

        // Same-leg gap is not checked
        clear_all();
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("same_a_deadf", deadf_a, 0);
        chk("same_b_deadf", deadf_b, 0);

        // Reset mid-period, then partial and exact periods
        tick(1, 0, 1, 0);
        repeat (6) tick(1, 0, 0, 0);
        RESET = 1'b1;
        tick(1, 0, 0, 0);
        chk("midrst_valid", valid_a, 0);
        chk("midrst_duty", duty_a, 0);
        RESET = 1'b0;
        tick(1, 0, 1, 0);
        tick(1, 0, 0, 0);
        chk("partial_valid", valid_a, 1);
        chk("partial_duty", duty_a, 0);
        chk("partial_dead", dead_a, 1);
        repeat (10) tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        repeat (6) tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 1, 0);
        tick(1, 0, 0, 0);
        chk("second_duty", duty_a, 6);
        chk("second_dead", dead_a, 2);
        chk("second_valid", valid_a, 1);

        // Random PWM periods
        repeat (40) begin
            period(int'($urandom_range(1, 2)), int'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
        end

        // Random bit patterns with occasional SYNC, CLEAR and RESET
        repeat (1500) begin
            int r, len;
            bit a, b;
            r = int'($urandom_range(0, 19));
            a = (r < 8) || (r == 19);
            b = (r >= 8 && r < 16) || (r == 19);
            len = int'($urandom_range(1, 4));
            repeat (len) begin
                RESET = ($urandom_range(0, 299) == 0);
                tick(a, b, $urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0);
            end
        end
        RESET = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
